multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit driving the control side of the team's 32-bit datapath (register file + ALU + 64x32 RAM). Fetches 32-bit instructions from an instruction ROM, decodes them, and sequences the datapath's register-address, ALU-op, write-enable and write-back-select inputs. It consumes the datapath's ZF/OF flags for branches and the optional overflow trap. It owns the PC and IR.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Inst_Addr  output  32  instruction ROM address (= PC)
- Inst_Data  input  32  ROM read data, combinational, valid in the same cycle as Inst_Addr
- ZF, OF  input  1 each  datapath ALU zero / overflow flags
- rs, rt, rd  output  5 each  register addresses, always IR[25:21], IR[20:16], IR[15:11]
- ALU_OP  output  3  ALU function select
- Write_Reg  output  1  register file write enable
- Mem_Write  output  1  data RAM write enable
- wr_data_s  output  2  write-back select: 00 ALU F, 01 RAM data
- State  output  3  current FSM state (debug)
- Halted  output  1  high in HALT
- Illegal  output  1  sticky: undefined opcode/funct decoded
- Ovf_Trap  output  1  sticky: overflow trap taken (0 when feature compiled out)

## Operation
- ALU_OP encoding: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLTU, 111 SLLV.
- Opcode IR[31:26]:
  - 000000 R-type; funct IR[5:0]: 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 100000 ADD, 100010 SUB, 101011 SLTU, 000100 SLLV; rd <= rs op rt.
  - 100011 LW: ALU_OP ADD, rd <= RAM[(rs+rt)[5:0]].
  - 101011 SW: ALU_OP ADD, RAM[(rs+rt)[5:0]] <= rt.
  - 000100 BEQ: ALU_OP SUB; if ZF, PC <= PC + (sign-extended IR[15:0] << 2) (PC already +4).
  - 000010 J: PC <= {PC[31:28], IR[25:0], 2'b00}.
  - 111111 HALT: enter HALT.
  - Anything else (incl. undefined funct): Illegal <= 1, treated as NOP.
- States (State code): FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 101.
- FETCH: IR <= Inst_Data, PC <= PC+4 (32-bit wrap); -> DECODE.
- DECODE: J updates PC -> FETCH; HALT -> HALT; illegal -> FETCH; else -> EXEC.
- EXEC: ALU_OP driven; R-type -> WB; LW/SW -> MEM; BEQ resolves -> FETCH.
- MEM: ALU_OP ADD held; SW asserts Mem_Write -> FETCH; LW -> WB.
- WB: Write_Reg=1; wr_data_s 00 (R-type) or 01 (LW); ALU_OP held from EXEC -> FETCH.
- HALT: all enables 0; exits only on Reset.
- Write_Reg and Mem_Write never both high; outside WB/MEM both 0; wr_data_s 00 except LW WB.

## Timing
- Control outputs are combinational from registered State and IR; PC, IR, State, flags are registered.
- Cycles per instruction: J 2, BEQ 3, R-type 4, SW 4, LW 5, illegal 2.
- Register/RAM writes commit on the clk edge ending WB/MEM.
- Reset (any state, incl. mid-instruction): next edge PC=PC_RESET, IR=0, State=FETCH, Illegal=0, Ovf_Trap=0; Write_Reg=0, Mem_Write=0, ALU_OP=000, wr_data_s=00, rs/rt/rd=0. Reset during WB/MEM blocks that cycle's write (enables forced 0 while Reset high).

## Configuration
- OVERFLOW_TRAP_EN defined: R-type ADD/SUB with OF=1 in EXEC skips WB (no register write), sets Ovf_Trap, -> HALT.
- Not defined: OF ignored, result written normally, Ovf_Trap constant 0.

## Test plan
- Reset then ROM[0]=ADD rd=3,rs=1,rt=2 -> Inst_Addr 0; Write_Reg high only in cycle 4 with rd=3, ALU_OP=100, wr_data_s=00; Inst_Addr=4 afterwards.
- SW rs=1,rt=2 then LW rd=5,rs=1,rt=2 -> Mem_Write one cycle in MEM (4th cycle); LW Write_Reg in 5th cycle with wr_data_s=01.
- BEQ at PC 8, offset 16'hFFFE: ZF=1 -> next Inst_Addr 4; ZF=0 -> 12; each 3 cycles.
- J at PC 32'h1000_0000, IR[25:0]=26'h40 -> next Inst_Addr 32'h1000_0100; opcode 6'b010101 -> Illegal=1, no write, Inst_Addr advances by 4.
- Reset asserted during WB of an ADD -> Write_Reg 0 that cycle, State=000, Inst_Addr=PC_RESET next cycle.
- With OVERFLOW_TRAP_EN, ADD with OF=1 -> no Write_Reg, Ovf_Trap=1, Halted=1, State=101 held; without it, Write_Reg pulses.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control-side bundle between multicycle_ctrl (master) and the instruction ROM / datapath (slave).
interface multicycle_ctrl_if;
   logic [31:0] Inst_Addr;
   logic [31:0] Inst_Data;
   logic        ZF;
   logic        OF;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [2:0]  ALU_OP;
   logic        Write_Reg;
   logic        Mem_Write;
   logic [1:0]  wr_data_s;
   logic [2:0]  State;
   logic        Halted;
   logic        Illegal;
   logic        Ovf_Trap;

   modport master (
      input  Inst_Data, ZF, OF,
      output Inst_Addr, rs, rt, rd, ALU_OP, Write_Reg, Mem_Write, wr_data_s,
             State, Halted, Illegal, Ovf_Trap
   );

   modport slave (
      output Inst_Data, ZF, OF,
      input  Inst_Addr, rs, rt, rd, ALU_OP, Write_Reg, Mem_Write, wr_data_s,
             State, Halted, Illegal, Ovf_Trap
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR for the 32-bit datapath.
// Optional feature: define OVERFLOW_TRAP_EN to halt on signed overflow of R-type ADD/SUB.
module multicycle_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              Reset,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'b000,
      S_DECODE = 3'b001,
      S_EXEC   = 3'b010,
      S_MEM    = 3'b011,
      S_WB     = 3'b100,
      S_HALT   = 3'b101
   } state_e;

   typedef enum logic [2:0] {I_RTYPE, I_LW, I_SW, I_BEQ, I_J, I_HALT, I_ILL} iclass_e;

   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b101;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;
   iclass_e     iclass;
   logic [2:0]  alu_dec;
   logic [31:0] br_off;
   logic        trap_take;
   logic [2:0]  alu_op;
   logic        write_reg;
   logic        mem_write;
   logic [1:0]  wr_sel;
   logic        unused_shamt;

   // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      iclass  = I_ILL;
      alu_dec = ALU_ADD;
      case (ir_q[31:26])
         6'b000000: begin
            iclass = I_RTYPE;
            case (ir_q[5:0])
               6'b100100: alu_dec = 3'b000;
               6'b100101: alu_dec = 3'b001;
               6'b100110: alu_dec = 3'b010;
               6'b100111: alu_dec = 3'b011;
               6'b100000: alu_dec = 3'b100;
               6'b100010: alu_dec = 3'b101;
               6'b101011: alu_dec = 3'b110;
               6'b000100: alu_dec = 3'b111;
               default:   iclass  = I_ILL;
            endcase
         end
         6'b100011: iclass = I_LW;
         6'b101011: iclass = I_SW;
         6'b000100: begin
            iclass  = I_BEQ;
            alu_dec = ALU_SUB;
         end
         6'b000010: iclass = I_J;
         6'b111111: iclass = I_HALT;
         default:   iclass = I_ILL;
      endcase
   end

   assign br_off       = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
   assign unused_shamt = ^ir_q[10:6];

`ifdef OVERFLOW_TRAP_EN
   logic ovf_q, ovf_d;

   assign trap_take = (state_q == S_EXEC) && (iclass == I_RTYPE) &&
                      ((alu_dec == ALU_ADD) || (alu_dec == ALU_SUB)) && bus.OF;
   assign ovf_d     = ovf_q | trap_take;

   always_ff @(posedge clk) begin
      if (Reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign bus.Ovf_Trap = ovf_q;
`else
   logic unused_of;

   assign unused_of    = bus.OF;
   assign trap_take    = 1'b0;
   assign bus.Ovf_Trap = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      alu_op    = 3'b000;
      write_reg = 1'b0;
      mem_write = 1'b0;
      wr_sel    = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_d    = bus.Inst_Data;
            pc_d    = pc_q + 32'd4;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (iclass)
               I_J: begin
                  // pc_q already holds PC+4 here, so the upper nibble is that of the next instruction.
                  pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                  state_d = S_FETCH;
               end
               I_HALT:  state_d = S_HALT;
               I_ILL: begin
                  illegal_d = 1'b1;
                  state_d   = S_FETCH;
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            alu_op = alu_dec;
            case (iclass)
               I_RTYPE: state_d = trap_take ? S_HALT : S_WB;
               I_BEQ: begin
                  if (bus.ZF) pc_d = pc_q + br_off;
                  state_d = S_FETCH;
               end
               default: state_d = S_MEM;
            endcase
         end
         S_MEM: begin
            alu_op    = ALU_ADD;
            mem_write = (iclass == I_SW);
            state_d   = (iclass == I_LW) ? S_WB : S_FETCH;
         end
         S_WB: begin
            alu_op    = alu_dec;
            write_reg = 1'b1;
            wr_sel    = (iclass == I_LW) ? 2'b01 : 2'b00;
            state_d   = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= S_FETCH;
         pc_q      <= PC_RESET;
         ir_q      <= 32'h0000_0000;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.Inst_Addr = pc_q;
   assign bus.rs        = ir_q[25:21];
   assign bus.rt        = ir_q[20:16];
   assign bus.rd        = ir_q[15:11];
   assign bus.ALU_OP    = alu_op;
   // Enables are masked by Reset so a write in flight never commits on the reset edge.
   assign bus.Write_Reg = write_reg & ~Reset;
   assign bus.Mem_Write = mem_write & ~Reset;
   assign bus.wr_data_s = wr_sel;
   assign bus.State     = state_q;
   assign bus.Halted    = (state_q == S_HALT);
   assign bus.Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instructions vs an ISA-level model.
module tb_multicycle_ctrl;

   typedef enum {C_R, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_ILL} cls_e;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   int          total = 0;
   int          bad = 0;
   logic [31:0] m_pc = 32'h0;
   logic        m_ill = 1'b0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // funct code for ALU op i, in ALU_OP encoding order
   function automatic logic [5:0] rfunct(input int i);
      case (i)
         0: return 6'b100100;
         1: return 6'b100101;
         2: return 6'b100110;
         3: return 6'b100111;
         4: return 6'b100000;
         5: return 6'b100010;
         6: return 6'b101011;
         default: return 6'b000100;
      endcase
   endfunction

   function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic void classify(input logic [31:0] ins, output cls_e c, output logic [2:0] op);
      c  = C_ILL;
      op = 3'b100;
      case (ins[31:26])
         6'h00: for (int i = 0; i < 8; i++) if (ins[5:0] == rfunct(i)) begin c = C_R; op = 3'(i); end
         6'h23: c = C_LW;
         6'h2B: c = C_SW;
         6'h04: begin c = C_BEQ; op = 3'b101; end
         6'h02: c = C_J;
         6'h3F: c = C_HALT;
         default: c = C_ILL;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge clk);
      Reset = 1'b1;
      bus.Inst_Data = $urandom;
      bus.ZF = 1'b0;
      bus.OF = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
      m_pc  = 32'h0;
      m_ill = 1'b0;
   endtask

   // Runs one non-HALT instruction from FETCH and checks every cycle against the ISA model.
   task automatic exec_instr(input string tag, input logic [31:0] ins, input logic zf, input logic ofl);
      cls_e        c;
      logic [2:0]  op;
      int          n;
      logic [31:0] npc;
      logic [2:0]  exp_st;
      logic [3:0]  exp_en;
      classify(ins, c, op);
      case (c)
         C_R:     n = 4;
         C_LW:    n = 5;
         C_SW:    n = 4;
         C_BEQ:   n = 3;
         default: n = 2;
      endcase
      npc = m_pc + 32'd4;
      if (c == C_J) npc = {npc[31:28], ins[25:0], 2'b00};
      if (c == C_BEQ && zf) npc = npc + (32'($signed(ins[15:0])) << 2);
      bus.Inst_Data = ins;
      bus.ZF = zf;
      bus.OF = ofl;
      for (int k = 0; k < n; k++) begin
         #1;
         exp_st = (k < 3) ? 3'(k) : ((c == C_R || k == 4) ? 3'd4 : 3'd3);
         exp_en = {(k == n - 1) && (c == C_R || c == C_LW), (c == C_SW) && (k == 3),
                   (c == C_LW && k == 4) ? 2'b01 : 2'b00};
         total++;
         if (bus.State !== exp_st) begin
            bad++;
            $display("FAIL %s state cyc%0d: got %b want %b", tag, k, bus.State, exp_st);
         end
         total++;
         if ({bus.Write_Reg, bus.Mem_Write, bus.wr_data_s} !== exp_en) begin
            bad++;
            $display("FAIL %s wr/mw/sel cyc%0d: got %b want %b", tag, k,
                     {bus.Write_Reg, bus.Mem_Write, bus.wr_data_s}, exp_en);
         end
         if (k == 0) begin
            total++;
            if (bus.Inst_Addr !== m_pc) begin
               bad++;
               $display("FAIL %s fetch addr: got %h want %h", tag, bus.Inst_Addr, m_pc);
            end
         end
         if (k >= 1) begin
            total++;
            if ({bus.rs, bus.rt, bus.rd} !== ins[25:11]) begin
               bad++;
               $display("FAIL %s regs cyc%0d: got %h want %h", tag, k, {bus.rs, bus.rt, bus.rd}, ins[25:11]);
            end
         end
         if (k >= 2) begin
            total++;
            if (bus.ALU_OP !== op) begin
               bad++;
               $display("FAIL %s alu_op cyc%0d: got %b want %b", tag, k, bus.ALU_OP, op);
            end
         end
         @(posedge clk);
         @(negedge clk);
      end
      m_pc = npc;
      if (c == C_ILL) m_ill = 1'b1;
      #1;
      total++;
      if ({bus.Inst_Addr, bus.Illegal, bus.Halted} !== {m_pc, m_ill, 1'b0}) begin
         bad++;
         $display("FAIL %s next pc/illegal/halted: got %h/%b/%b want %h/%b/0", tag,
                  bus.Inst_Addr, bus.Illegal, bus.Halted, m_pc, m_ill);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if ({bus.State, bus.Inst_Addr, bus.rs, bus.rt, bus.rd} !== {3'b000, 32'h0, 15'h0}) begin
         bad++;
         $display("FAIL reset state/pc/regs: got %b %h %h", bus.State, bus.Inst_Addr, {bus.rs, bus.rt, bus.rd});
      end
      total++;
      if ({bus.ALU_OP, bus.Write_Reg, bus.Mem_Write, bus.wr_data_s, bus.Illegal, bus.Ovf_Trap, bus.Halted}
          !== 10'b0) begin
         bad++;
         $display("FAIL reset outputs: got %b want 0", {bus.ALU_OP, bus.Write_Reg, bus.Mem_Write,
                  bus.wr_data_s, bus.Illegal, bus.Ovf_Trap, bus.Halted});
      end
   endtask

   task automatic test_add();
      exec_instr("add", r_inst(5'd1, 5'd2, 5'd3, 6'b100000), 1'b0, 1'b0);
   endtask

   task automatic test_mem();
      exec_instr("sw", {6'h2B, 5'd1, 5'd2, 16'h0000}, 1'b0, 1'b0);
   endtask

   task automatic test_branch();
      exec_instr("beq_taken", {6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b1, 1'b0);
      exec_instr("lw", {6'h23, 5'd1, 5'd2, 5'd5, 11'h0}, 1'b0, 1'b0);
      exec_instr("beq_not_taken", {6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 1'b0);
   endtask

   task automatic test_jump_illegal();
      exec_instr("j_far", {6'h02, 26'h3FF_FFFF}, 1'b0, 1'b0);
      exec_instr("or_at_top", r_inst(5'd4, 5'd6, 5'd8, 6'b100101), 1'b0, 1'b0);
      exec_instr("j_hi", {6'h02, 26'h000_0040}, 1'b0, 1'b0);
      exec_instr("illegal_op", {6'b010101, 26'h155_AAAA}, 1'b0, 1'b0);
      exec_instr("bad_funct", r_inst(5'd1, 5'd1, 5'd1, 6'b111110), 1'b1, 1'b0);
   endtask

   task automatic test_reset_in_wb();
      do_reset();
      exec_instr("ill_pre", {6'b010101, 26'h0000123}, 1'b0, 1'b0);
      bus.Inst_Data = r_inst(5'd4, 5'd5, 5'd6, 6'b100000);
      repeat (3) @(posedge clk);
      @(negedge clk);
      Reset = 1'b1;
      #1;
      total++;
      if ({bus.State, bus.Write_Reg, bus.Mem_Write} !== {3'b100, 2'b00}) begin
         bad++;
         $display("FAIL wb_reset enables: got state %b wr %b mw %b want 100/0/0",
                  bus.State, bus.Write_Reg, bus.Mem_Write);
      end
      @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
      m_pc  = 32'h0;
      m_ill = 1'b0;
      #1;
      total++;
      if ({bus.State, bus.Inst_Addr, bus.Illegal, bus.rs, bus.rt, bus.rd, bus.ALU_OP, bus.wr_data_s}
          !== {3'b000, 32'h0, 1'b0, 15'h0, 3'b000, 2'b00}) begin
         bad++;
         $display("FAIL wb_reset after: got state %b pc %h ill %b regs %h alu %b sel %b", bus.State,
                  bus.Inst_Addr, bus.Illegal, {bus.rs, bus.rt, bus.rd}, bus.ALU_OP, bus.wr_data_s);
      end
   endtask

   task automatic test_halt();
      do_reset();
      bus.Inst_Data = 32'hFC00_0000;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         #1;
         total++;
         if ({bus.State, bus.Halted, bus.Write_Reg, bus.Mem_Write, bus.Inst_Addr} !== {3'b101, 3'b100, 32'h4}) begin
            bad++;
            $display("FAIL halt cyc%0d: got state %b halted %b wr %b mw %b pc %h", k, bus.State,
                     bus.Halted, bus.Write_Reg, bus.Mem_Write, bus.Inst_Addr);
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_overflow();
      do_reset();
`ifdef OVERFLOW_TRAP_EN
      bus.Inst_Data = r_inst(5'd7, 5'd8, 5'd9, 6'b100000);
      bus.OF = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if ({bus.State, bus.Halted, bus.Ovf_Trap, bus.Write_Reg} !== 6'b101110) begin
            bad++;
            $display("FAIL ovf_trap cyc%0d: got state %b halted %b trap %b wr %b", k, bus.State,
                     bus.Halted, bus.Ovf_Trap, bus.Write_Reg);
         end
         @(posedge clk);
         @(negedge clk);
      end
      bus.OF = 1'b0;
`else
      exec_instr("add_of", r_inst(5'd7, 5'd8, 5'd9, 6'b100000), 1'b0, 1'b1);
      total++;
      if (bus.Ovf_Trap !== 1'b0) begin
         bad++;
         $display("FAIL ovf_disabled trap: got %b want 0", bus.Ovf_Trap);
      end
`endif
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic        ofl;
      cls_e        c;
      logic [2:0]  op;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 6))
            0, 1: ins = r_inst(5'($urandom), 5'($urandom), 5'($urandom), rfunct(int'($urandom_range(0, 7))));
            2:    ins = {6'h23, 26'($urandom)};
            3:    ins = {6'h2B, 26'($urandom)};
            4:    ins = {6'h04, 26'($urandom)};
            5:    ins = {6'h02, 26'($urandom)};
            default: begin
               do begin
                  ins = $urandom;
                  if ($urandom_range(0, 1) == 1) ins[31:26] = 6'h00;
                  classify(ins, c, op);
               end while (c != C_ILL);
            end
         endcase
`ifdef OVERFLOW_TRAP_EN
         ofl = 1'b0;
`else
         ofl = 1'($urandom);
`endif
         exec_instr("random", ins, 1'($urandom), ofl);
      end
   endtask

   initial begin
      bus.Inst_Data = 32'h0;
      bus.ZF = 1'b0;
      bus.OF = 1'b0;
      test_reset();
      test_add();
      test_mem();
      test_branch();
      test_jump_illegal();
      test_reset_in_wb();
      test_halt();
      test_overflow();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
